uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the number of stored bytes (power of two).
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning the data byte width.
REQ-003 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-004 Port clock_in  input  1  system clock; all logic on its rising edge.
REQ-005 Port reset  input  1  synchronous active-high reset.
REQ-006 Port rx_data  input  WIDTH  byte from the serial-to-parallel receiver.
REQ-007 Port rx_valid  input  1  one-cycle strobe; rx_data is valid in this cycle.
REQ-008 Port rd_en  input  1  MCU read request; pops one byte.
REQ-009 Port clr_overrun  input  1  one-cycle clear of the sticky overrun flag.
REQ-010 Port rd_data  output  WIDTH  registered popped byte.
REQ-011 Port rd_valid  output  1  one-cycle strobe; rd_data is valid.
REQ-012 Port empty  output  1  high when count == 0.
REQ-013 Port full  output  1  high when count == DEPTH.
REQ-014 Port overrun  output  1  sticky; a byte was dropped.
REQ-015 Port count  output  log2(DEPTH)+1  number of stored bytes (0..DEPTH).
REQ-016 Port status  output  16  {8'h00, count[3:0], half, overrun, full, empty}; half = (count >= DEPTH/2).

Function
REQ-017 A push SHALL occur on rx_valid when not full, or when full with rd_en in the same cycle.
REQ-018 A pop SHALL occur on rd_en when not empty; rd_en while empty SHALL be ignored, with rd_valid low and rd_data held.
REQ-019 A pop SHALL drive rd_data with the oldest byte and assert rd_valid on the cycle after rd_en (latency 1).
REQ-020 Data SHALL NOT fall through: push and rd_en on an empty FIFO SHALL accept the push and ignore the read.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-022 The write and read pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH without extra logic.
REQ-023 count SHALL increment on push-only, decrement on pop-only, and never exceed DEPTH or go below 0.
REQ-024 rx_valid while full and without rd_en SHALL drop rx_data, leave storage unchanged, and set overrun on the next edge.
REQ-025 overrun SHALL stay set until clr_overrun; if set and clear coincide, set SHALL win.
REQ-026 empty, full, half and count SHALL be registered and consistent with each other every cycle.
REQ-027 Storage contents SHALL NOT be cleared by reset; only pointers and flags reset.

Reset
REQ-028 On reset the block SHALL set: pointers 0, count 0, empty 1, full 0, overrun 0, rd_valid 0, rd_data 0, status 16'h0001.
REQ-029 Reset asserted mid-operation SHALL discard all stored bytes and override any coincident push, pop or clear in that cycle.

Structure
REQ-030 Shared package uart_pkg SHALL hold the DEPTH/WIDTH defaults and the status bit positions (EMPTY=0, FULL=1, OVR=2, HALF=3, COUNT=7:4).
REQ-031 Storage SHALL be one sub-module, uart_fifo_ram: DEPTH x WIDTH, one write port, one synchronous read port.
REQ-032 Control (pointers, count, flags) SHALL reside in uart_rx_fifo.

Verification
REQ-033 Reset, then push 8'hA5, then rd_en -> rd_data=8'hA5, rd_valid for one cycle, count 1->0, status 16'h0001.
REQ-034 Push 8'h01..8'h08 -> full=1, count=8, status=16'h008A; pop 8 times -> data 01..08 in order, empty=1.
REQ-035 When full, push 8'hFF without rd_en -> overrun=1, count stays 8, the pops return 01..08 with no FF; clr_overrun -> overrun=0.
REQ-036 When full, push 8'h09 together with rd_en -> rd_data=8'h01, count stays 8, and the last pop returns 8'h09.
REQ-037 When empty, push 8'h3C together with rd_en -> rd_valid=0, count=1; the next rd_en returns 8'h3C.
REQ-038 With 5 bytes stored, assert reset -> count=0, empty=1, overrun=0; the next push/pop returns only the new byte.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared defaults and status-word layout for the UART receive FIFO.
// The packing helper keeps the status bit positions defined in one place.
package uart_pkg;

    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_WIDTH = 8;

    localparam int STATUS_EMPTY     = 0;
    localparam int STATUS_FULL      = 1;
    localparam int STATUS_OVR       = 2;
    localparam int STATUS_HALF      = 3;
    localparam int STATUS_COUNT_LSB = 4;
    localparam int STATUS_COUNT_MSB = 7;

    function automatic logic [15:0] pack_status(
        input logic [3:0] cnt,
        input logic       half,
        input logic       ovr,
        input logic       full,
        input logic       empty
    );
        logic [15:0] s;
        s                                     = '0;
        s[STATUS_EMPTY]                       = empty;
        s[STATUS_FULL]                        = full;
        s[STATUS_OVR]                         = ovr;
        s[STATUS_HALF]                        = half;
        s[STATUS_COUNT_MSB:STATUS_COUNT_LSB]  = cnt;
        return s;
    endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// DEPTH x WIDTH byte store: one write port, one registered read port.
// Storage is never reset; only the read register is cleared.
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-before-write: a read and write to the same slot in one cycle
    // returns the old byte, which a push-while-full-and-popping relies on.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between a UART deserialiser and an MCU: pointers, count,
// flags and the sticky overrun live here; bytes live in uart_fifo_ram.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic [WIDTH-1:0] rx_data,
    input  logic             rx_valid,
    input  logic             rd_en,
    input  logic             clr_overrun,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             empty,
    output logic             full,
    output logic             overrun,
    output logic [CW-1:0]    count,
    output logic [15:0]      status
);

    // Strobe semantics: rx_valid offers a byte for exactly one cycle and is
    // never back-pressured (dropped when no room). rd_en requests one pop;
    // rd_valid answers one cycle later for one cycle, only if a byte existed.

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          half;
    logic          push;
    logic          pop;
    logic          ovr_set;
    logic [CW-1:0] count_next;

    always_comb begin
        push       = rx_valid && (!full || rd_en);
        pop        = rd_en && !empty;
        ovr_set    = rx_valid && full && !rd_en;
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            half     <= 1'b0;
            overrun  <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            // Flags come from the next count so they never lag it.
            count    <= count_next;
            empty    <= (count_next == '0);
            full     <= (count_next == CW'(DEPTH));
            half     <= (count_next >= CW'(DEPTH / 2));
            overrun  <= ovr_set || (overrun && !clr_overrun);
            rd_valid <= pop;
        end
    end

    uart_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clock_in),
        .rst   (reset),
        .we    (push && !reset),
        .waddr (wr_ptr),
        .wdata (rx_data),
        .re    (pop && !reset),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_comb begin
        status = pack_status(4'(count), half, overrun, full, empty);
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed table, hand-written corner sequences and
// a randomized run, all checked against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;

    logic             clock_in;
    logic             reset;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rd_en;
    logic             clr_overrun;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             empty;
    logic             full;
    logic             overrun;
    logic [3:0]       count;
    logic [15:0]      status;

    uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock_in    (clock_in),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rd_en       (rd_en),
        .clr_overrun (clr_overrun),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .empty       (empty),
        .full        (full),
        .overrun     (overrun),
        .count       (count),
        .status      (status)
    );

    // Clock and initial input levels
    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    initial begin
        reset       = 1'b1;
        rx_data     = '0;
        rx_valid    = 1'b0;
        rd_en       = 1'b0;
        clr_overrun = 1'b0;
    end

    int tests = 0;
    int fails = 0;

    // Reference model: stored bytes as a queue, plus the output registers
    logic [WIDTH-1:0] model_q[$];
    logic             model_ovr = 1'b0;
    logic             model_rdv = 1'b0;
    logic [WIDTH-1:0] model_rdd = '0;

    // Scoreboard of bytes the model has popped and the DUT must deliver
    logic [WIDTH-1:0] exp_q[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_status();
        int c;
        c = model_q.size();
        return 16'(((c % 16) << 4) | ((c >= DEPTH / 2) ? 8 : 0) | (model_ovr ? 4 : 0)
                   | ((c == DEPTH) ? 2 : 0) | ((c == 0) ? 1 : 0));
    endfunction

    // Driver: applies one cycle of inputs, steps the model, checks everything
    task automatic cycle(input logic rxv, input logic [WIDTH-1:0] d, input logic rde,
                         input logic clr, input logic rst);
        logic       was_full;
        logic       do_push;
        logic       do_pop;
        logic [WIDTH-1:0] popped;
        logic [WIDTH-1:0] exp_byte;
        rx_valid    = rxv;
        rx_data     = d;
        rd_en       = rde;
        clr_overrun = clr;
        reset       = rst;
        if (rst) begin
            model_q.delete();
            exp_q.delete();
            model_ovr = 1'b0;
            model_rdv = 1'b0;
            model_rdd = '0;
        end else begin
            was_full  = (model_q.size() == DEPTH);
            do_pop    = rde && (model_q.size() != 0);
            do_push   = rxv && (!was_full || rde);
            model_rdv = do_pop;
            if (do_pop) begin
                popped    = model_q.pop_front();
                model_rdd = popped;
                exp_q.push_back(popped);
            end
            if (do_push) model_q.push_back(d);
            if (rxv && was_full && !rde) model_ovr = 1'b1;
            else if (clr)                model_ovr = 1'b0;
        end
        @(posedge clock_in);
        #1;
        check("count",    16'(count),    16'(model_q.size()));
        check("empty",    16'(empty),    16'(model_q.size() == 0));
        check("full",     16'(full),     16'(model_q.size() == DEPTH));
        check("overrun",  16'(overrun),  16'(model_ovr));
        check("status",   status,        model_status());
        check("rd_valid", 16'(rd_valid), 16'(model_rdv));
        check("rd_data",  16'(rd_data),  16'(model_rdd));
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_pop", 16'(rd_data), 16'hFFFF);
            end else begin
                exp_byte = exp_q.pop_front();
                check("sb_data", 16'(rd_data), 16'(exp_byte));
            end
        end
    endtask

    task automatic fill(input int n, input int base);
        for (int i = 0; i < n; i++) cycle(1'b1, WIDTH'(base + i), 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic             rst;
        logic             rxv;
        logic [WIDTH-1:0] d;
        logic             rde;
        logic             clr;
        logic [3:0]       e_count;
        logic             e_rdv;
        logic [WIDTH-1:0] e_rdd;
        logic [15:0]      e_status;
    } vec_t;

    vec_t vecs[8];

    initial begin
        // rst rxv data  rde clr | count rdv rdd    status
        vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 16'h0001};
        vecs[1] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 4'd1, 1'b0, 8'h00, 16'h0010};
        vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b1, 8'hA5, 16'h0001};
        vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 8'hA5, 16'h0001};
        vecs[4] = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 4'd1, 1'b0, 8'hA5, 16'h0010};
        vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b1, 8'h3C, 16'h0001};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0, 8'h3C, 16'h0001};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b0, 8'h3C, 16'h0001};

        repeat (2) @(posedge clock_in);
        #1;

        // Directed table: reset, single byte, push+read on empty, read on empty
        for (int i = 0; i < 8; i++) begin
            cycle(vecs[i].rxv, vecs[i].d, vecs[i].rde, vecs[i].clr, vecs[i].rst);
            check($sformatf("vec%0d_count", i),  16'(count),    16'(vecs[i].e_count));
            check($sformatf("vec%0d_rdv", i),    16'(rd_valid), 16'(vecs[i].e_rdv));
            check($sformatf("vec%0d_rdd", i),    16'(rd_data),  16'(vecs[i].e_rdd));
            check($sformatf("vec%0d_status", i), status,        vecs[i].e_status);
        end

        // Fill to full, overrun, set/clear collision, clear, drain in order
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        fill(8, 1);
        check("full_status", status, 16'h008A);
        cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        check("ovr_set", 16'(overrun), 16'h1);
        check("ovr_count", 16'(count), 16'h8);
        cycle(1'b1, 8'hFE, 1'b0, 1'b1, 1'b0);
        check("ovr_set_wins", 16'(overrun), 16'h1);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("ovr_clear", 16'(overrun), 16'h0);
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
            check("drain_order", 16'(rd_data), 16'(i));
        end
        check("drained_status", status, 16'h0001);

        // Push while full with a concurrent pop
        fill(8, 1);
        cycle(1'b1, 8'h09, 1'b1, 1'b0, 1'b0);
        check("full_pushpop_data", 16'(rd_data), 16'h0001);
        check("full_pushpop_count", 16'(count), 16'h8);
        check("full_pushpop_ovr", 16'(overrun), 16'h0);
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("last_pop_09", 16'(rd_data), 16'h0009);

        // Reset mid-operation overrides a coincident push, pop and clear
        fill(5, 8'h40);
        cycle(1'b1, 8'hEE, 1'b1, 1'b1, 1'b1);
        check("rst_count", 16'(count), 16'h0);
        check("rst_empty", 16'(empty), 16'h1);
        check("rst_ovr", 16'(overrun), 16'h0);
        check("rst_status", status, 16'h0001);
        cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("post_rst_data", 16'(rd_data), 16'h0077);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("post_rst_only_one", 16'(rd_valid), 16'h0);

        // Randomized traffic in fill / drain / mixed phases
        for (int k = 0; k < 900; k++) begin
            int phase;
            logic rxv;
            logic rde;
            phase = (k / 60) % 3;
            case (phase)
                0:       begin rxv = ($urandom_range(0, 9) < 8); rde = ($urandom_range(0, 9) < 2); end
                1:       begin rxv = ($urandom_range(0, 9) < 2); rde = ($urandom_range(0, 9) < 8); end
                default: begin rxv = ($urandom_range(0, 1) == 1); rde = ($urandom_range(0, 1) == 1); end
            endcase
            cycle(rxv, WIDTH'($urandom), rde, ($urandom_range(0, 19) == 0), ($urandom_range(0, 149) == 0));
        end

        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
